// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch unit, the data port, the shared
// memory and the memory arbiter. The master modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_gnt_o;
  logic              if_rvalid_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              dm_req_i;
  logic              dm_we_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic              dm_gnt_o;
  logic              dm_rvalid_o;
  logic [DATA_W-1:0] dm_rdata_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_wr_o;
  logic              mem_op_en_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_ready_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              stall_o;

  modport master (
    input  if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i,
           dm_wdata_i, mem_ready_i, mem_rdata_i,
    output if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
           mem_addr_o, mem_rd_wr_o, mem_op_en_o, mem_wdata_o, stall_o
  );

  modport slave (
    output if_req_i, if_addr_i, if_flush_i, dm_req_i, dm_we_i, dm_addr_i,
           dm_wdata_i, mem_ready_i, mem_rdata_i,
    input  if_gnt_o, if_rvalid_o, if_rdata_o, dm_gnt_o, dm_rvalid_o, dm_rdata_o,
           mem_addr_o, mem_rd_wr_o, mem_op_en_o, mem_wdata_o, stall_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between instruction fetch
// and data access. Define MEM_ARB_RR_EN for round-robin on contention (default: dm > if).
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  mem_arbiter_if.master bus
);

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  typedef enum logic [1:0] {IDLE, SERVE_IF, SERVE_DM} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_gnt_if;
  logic              w_gnt_dm;
  logic              w_pick_dm;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;
  logic              r_flush_seen;
  logic              r_if_rvalid;
  logic              r_dm_rvalid;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;
`ifdef MEM_ARB_RR_EN
  logic              r_last_dm;
`endif

  always_comb begin
    w_next    = r_state;
    w_gnt_if  = 1'b0;
    w_gnt_dm  = 1'b0;
    w_pick_dm = bus.dm_req_i;
`ifdef MEM_ARB_RR_EN
    // On contention the requester not served last wins.
    if (bus.dm_req_i && bus.if_req_i) w_pick_dm = ~r_last_dm;
`endif
    case (r_state)
      IDLE: begin
        if (reset_n) begin
          if (w_pick_dm) begin
            w_gnt_dm = 1'b1;
            w_next   = SERVE_DM;
          end else if (bus.if_req_i) begin
            w_gnt_if = 1'b1;
            w_next   = SERVE_IF;
          end
        end
      end
      SERVE_IF, SERVE_DM: begin
        if (bus.mem_ready_i) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_we         <= RD;
      r_wdata      <= '0;
      r_flush_seen <= 1'b0;
      r_if_rvalid  <= 1'b0;
      r_dm_rvalid  <= 1'b0;
      r_if_rdata   <= '0;
      r_dm_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
      r_last_dm    <= 1'b0;
`endif
    end else begin
      r_state     <= w_next;
      r_if_rvalid <= 1'b0;
      r_dm_rvalid <= 1'b0;
      if (w_gnt_if || w_gnt_dm) begin
        r_addr       <= w_gnt_dm ? bus.dm_addr_i : bus.if_addr_i;
        r_we         <= w_gnt_dm ? bus.dm_we_i : RD;
        r_flush_seen <= 1'b0;
`ifdef MEM_ARB_RR_EN
        r_last_dm    <= w_gnt_dm;
`endif
      end
      // Fetches keep the previous write data on the bus; it is unused for reads.
      if (w_gnt_dm) r_wdata <= bus.dm_wdata_i;
      if (r_state == SERVE_IF) begin
        if (bus.if_flush_i) r_flush_seen <= 1'b1;
        if (bus.mem_ready_i && !bus.if_flush_i && !r_flush_seen) begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= bus.mem_rdata_i;
        end
      end
      if (r_state == SERVE_DM && bus.mem_ready_i) begin
        r_dm_rvalid <= 1'b1;
        if (r_we == RD) r_dm_rdata <= bus.mem_rdata_i;
      end
    end
  end

  assign bus.if_gnt_o    = w_gnt_if;
  assign bus.dm_gnt_o    = w_gnt_dm;
  assign bus.if_rvalid_o = r_if_rvalid;
  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.dm_rvalid_o = r_dm_rvalid;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.mem_op_en_o = (r_state != IDLE);
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_rd_wr_o = r_we;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.stall_o     = reset_n &
                           ((bus.if_req_i & ~w_gnt_if) | (bus.dm_req_i & ~w_gnt_dm));

endmodule
